// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch
// ----------------------------------------------------------------------------
// Instruction fetch stage for the cpu4 core. It issues read addresses to a
// synchronous program ROM, which has a one-cycle read latency. Returned words
// are buffered in a two-entry prefetch queue. The queue head is presented to
// decode through a valid/ready handshake.
//
// A redirect from the core (jump/branch) flushes every buffered word and any
// read still in flight. Fetch then restarts at the redirect target.
//
// Parameters
//   ADDR_WIDTH   program counter / ROM address width
//   INSTR_WIDTH  instruction word width
//   RESET_PC     first fetch address after reset
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   reset        asynchronous, active-high reset
//   rom_en       ROM read enable (a read is issued this cycle)
//   rom_addr     ROM read address; the matching rom_data arrives next cycle
//   rom_data     ROM read data for the previous cycle's rom_en
//   instr_valid  instr/instr_pc hold a valid fetched word
//   instr        head-of-queue instruction
//   instr_pc     address the head instruction was fetched from
//   instr_ready  decode accepts the head this cycle
//   redirect     flush and restart fetching at redirect_pc
//   redirect_pc  new fetch address
// ============================================================================
module instr_fetch #(
    parameter int unsigned           ADDR_WIDTH  = 8,
    parameter int unsigned           INSTR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   rom_en,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [INSTR_WIDTH-1:0] rom_data,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    input  logic                   instr_ready,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc
);

    // Next address to be issued to the ROM
    logic [ADDR_WIDTH-1:0]  fetchPc_q,    fetchPc_d;

    // A read was issued last cycle; its data is on rom_data now
    logic                   inflight_q,   inflight_d;
    logic [ADDR_WIDTH-1:0]  inflightPc_q, inflightPc_d;

    // Two-entry prefetch queue: head is entry 0, tail is entry 1
    logic [ADDR_WIDTH-1:0]  headPc_q,     headPc_d;
    logic [INSTR_WIDTH-1:0] headWord_q,   headWord_d;
    logic [ADDR_WIDTH-1:0]  tailPc_q,     tailPc_d;
    logic [INSTR_WIDTH-1:0] tailWord_q,   tailWord_d;
    logic [1:0]             count_q,      count_d;

    logic                   pop;
    logic                   append;
    logic [2:0]             occupancy;

    // A pop is cancelled by a redirect: the head is flushed, not consumed
    assign instr_valid = (count_q != 2'd0);
    assign instr       = headWord_q;
    assign instr_pc    = headPc_q;
    assign pop         = instr_valid & instr_ready & ~redirect;
    assign append      = inflight_q & ~redirect;

    // Issue only when the word coming back can be guaranteed a slot. The
    // occupancy counts buffered words plus the word still in flight, minus the
    // slot freed by this cycle's pop. This keeps count + inflight <= 2, so a
    // returning word always has a free slot and is never dropped.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rom_en    = ~reset & ~redirect & (occupancy < 3'd2);
    assign rom_addr  = fetchPc_q;

    // Next-state logic for the fetch pointer, the in-flight tracker and the
    // queue. A redirect overrides everything in its cycle. The queue empties,
    // and the returning ROM word is discarded by clearing the in-flight flag.
    // Otherwise the queue handles four cases: hold, pop only, append only,
    // or both. With both, the head shifts out and the new word lands behind
    // it, so the count is unchanged.
    always_comb begin
        fetchPc_d    = fetchPc_q;
        inflight_d   = 1'b0;
        inflightPc_d = inflightPc_q;
        headPc_d     = headPc_q;
        headWord_d   = headWord_q;
        tailPc_d     = tailPc_q;
        tailWord_d   = tailWord_q;
        count_d      = count_q;

        if (redirect) begin
            fetchPc_d  = redirect_pc;
            inflight_d = 1'b0;
            count_d    = 2'd0;
        end else begin
            if (rom_en) begin
                fetchPc_d    = fetchPc_q + ADDR_WIDTH'(1);
                inflight_d   = 1'b1;
                inflightPc_d = fetchPc_q;
            end

            case ({pop, append})
                2'b10: begin
                    headPc_d   = tailPc_q;
                    headWord_d = tailWord_q;
                    count_d    = count_q - 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd0) begin
                        headPc_d   = inflightPc_q;
                        headWord_d = rom_data;
                    end else begin
                        tailPc_d   = inflightPc_q;
                        tailWord_d = rom_data;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        headPc_d   = tailPc_q;
                        headWord_d = tailWord_q;
                        tailPc_d   = inflightPc_q;
                        tailWord_d = rom_data;
                    end else begin
                        headPc_d   = inflightPc_q;
                        headWord_d = rom_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State registers. An asynchronous reset clears the queue and the
    // in-flight flag at once, so a pending ROM word is never delivered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchPc_q    <= RESET_PC;
            inflight_q   <= 1'b0;
            inflightPc_q <= '0;
            headPc_q     <= '0;
            headWord_q   <= '0;
            tailPc_q     <= '0;
            tailWord_q   <= '0;
            count_q      <= 2'd0;
        end else begin
            fetchPc_q    <= fetchPc_d;
            inflight_q   <= inflight_d;
            inflightPc_q <= inflightPc_d;
            headPc_q     <= headPc_d;
            headWord_q   <= headWord_d;
            tailPc_q     <= tailPc_d;
            tailWord_q   <= tailWord_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// ============================================================================
// tb_instr_fetch
// ----------------------------------------------------------------------------
// Bench for instr_fetch. A behavioural model mirrors the fetch stage with a
// queue of {pc, word} pairs and a pending-read flag. Each cycle a single
// checker compares the DUT against the model. A directed sequence pins the
// model with hand-computed values, and a random phase follows it.
// A second instance, with RESET_PC = 8'hFE, shows the fetch pointer wrapping
// around right after reset.
// ============================================================================
module tb_instr_fetch;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] word;
    } entry_t;

    logic        clk;
    logic        reset;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        instr_valid;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;

    logic        reset1;
    logic        rom_en1;
    logic [7:0]  rom_addr1;
    logic [15:0] rom_data1;
    logic        instr_valid1;
    logic [15:0] instr1;
    logic [7:0]  instr_pc1;
    logic        instr_ready1;
    logic        redirect1;
    logic [7:0]  redirect_pc1;

    int compared;
    int mismatched;

    entry_t     mq[$];
    logic [7:0] mFetch;
    bit         mPend;
    logic [7:0] mPendPc;

    instr_fetch #(.ADDR_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .instr_ready(instr_ready), .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    instr_fetch #(.ADDR_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(8'hFE)) dutWrap (
        .clk(clk), .reset(reset1), .rom_en(rom_en1), .rom_addr(rom_addr1),
        .rom_data(rom_data1), .instr_valid(instr_valid1), .instr(instr1),
        .instr_pc(instr_pc1), .instr_ready(instr_ready1), .redirect(redirect1),
        .redirect_pc(redirect_pc1)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous program ROMs holding A000 + address, with one cycle latency
    always @(posedge clk) begin
        if (rom_en)  rom_data  <= 16'hA000 + {8'h00, rom_addr};
        if (rom_en1) rom_data1 <= 16'hA000 + {8'h00, rom_addr1};
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Changes the inputs shortly after the next rising edge; they then hold
    // for that whole cycle
    task automatic applyStimulus(input bit rdy, input bit rd, input logic [7:0] rpc);
        @(posedge clk);
        #1;
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
    endtask

    // Model comparison on every falling edge. Expected outputs come from the
    // model state plus the inputs for this cycle. The model then advances to
    // what the next rising edge must produce.
    always @(negedge clk) begin
        bit  expValid;
        bit  expPop;
        bit  expEn;
        int  occ;
        if (reset) begin
            checkOutput("reset rom_en", 32'(rom_en), 32'd0);
            checkOutput("reset instr_valid", 32'(instr_valid), 32'd0);
            checkOutput("reset instr", 32'(instr), 32'd0);
            checkOutput("reset instr_pc", 32'(instr_pc), 32'd0);
            mq.delete();
            mFetch = 8'h00;
            mPend  = 1'b0;
        end else begin
            expValid = (mq.size() != 0);
            expPop   = expValid && instr_ready && !redirect;
            occ      = mq.size() + int'(mPend) - int'(expPop);
            expEn    = !redirect && (occ < 2);
            checkOutput("model rom_en", 32'(rom_en), 32'(expEn));
            checkOutput("model rom_addr", 32'(rom_addr), 32'(mFetch));
            checkOutput("model instr_valid", 32'(instr_valid), 32'(expValid));
            if (expValid) begin
                checkOutput("model instr_pc", 32'(instr_pc), 32'(mq[0].pc));
                checkOutput("model instr", 32'(instr), 32'(mq[0].word));
            end
            if (redirect) begin
                mq.delete();
                mPend  = 1'b0;
                mFetch = redirect_pc;
            end else begin
                if (expPop) void'(mq.pop_front());
                if (mPend) mq.push_back({mPendPc, 16'hA000 + {8'h00, mPendPc}});
                if (expEn) begin
                    mPendPc = mFetch;
                    mFetch  = mFetch + 8'd1;
                    mPend   = 1'b1;
                end else begin
                    mPend = 1'b0;
                end
            end
            checkOutput("model occupancy", 32'(mq.size() > 2), 32'd0);
        end
    end

    initial begin
        reset        = 1'b1;
        reset1       = 1'b1;
        instr_ready  = 1'b1;
        redirect     = 1'b0;
        redirect_pc  = 8'h00;
        instr_ready1 = 1'b1;
        redirect1    = 1'b0;
        redirect_pc1 = 8'h00;
        compared     = 0;
        mismatched   = 0;

        // Reset release, streaming with ready held high
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        reset1 = 1'b0;
        @(negedge clk);
        checkOutput("c0 rom_en", 32'(rom_en), 32'd1);
        checkOutput("c0 rom_addr", 32'(rom_addr), 32'h00);
        @(negedge clk);
        checkOutput("c1 instr_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        checkOutput("c2 instr_valid", 32'(instr_valid), 32'd1);
        checkOutput("c2 instr_pc", 32'(instr_pc), 32'h00);
        checkOutput("c2 instr", 32'(instr), 32'hA000);
        checkOutput("wrap c2 instr_valid", 32'(instr_valid1), 32'd1);
        checkOutput("wrap c2 instr_pc", 32'(instr_pc1), 32'hFE);
        checkOutput("wrap c2 instr", 32'(instr1), 32'hA0FE);
        for (int k = 1; k <= 3; k++) begin
            logic [7:0] wpc;
            @(negedge clk);
            wpc = 8'hFE + 8'(k);
            checkOutput("stream instr_pc", 32'(instr_pc), 32'(k));
            checkOutput("stream instr", 32'(instr), 32'hA000 + 32'(k));
            checkOutput("wrap instr_pc", 32'(instr_pc1), 32'(wpc));
            checkOutput("wrap instr", 32'(instr1), 32'hA000 + 32'(wpc));
        end

        // Stall for several cycles from reset: two words buffered, then no more reads
        @(posedge clk);
        #1;
        reset       = 1'b1;
        instr_ready = 1'b0;
        #1;
        checkOutput("async reset instr_valid", 32'(instr_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("stall rom_en", 32'(rom_en), 32'd0);
        checkOutput("stall instr_valid", 32'(instr_valid), 32'd1);
        checkOutput("stall instr", 32'(instr), 32'hA000);
        checkOutput("stall instr_pc", 32'(instr_pc), 32'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int k = 0; k <= 2; k++) begin
            if (k != 0) @(negedge clk);
            else @(negedge clk);
            checkOutput("drain instr_pc", 32'(instr_pc), 32'(k));
        end

        // Redirect while a head pop and a read are pending in the same cycle
        applyStimulus(1'b1, 1'b1, 8'h40);
        @(negedge clk);
        checkOutput("redir rom_en", 32'(rom_en), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("redir+1 rom_en", 32'(rom_en), 32'd1);
        checkOutput("redir+1 rom_addr", 32'(rom_addr), 32'h40);
        checkOutput("redir+1 instr_valid", 32'(instr_valid), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("redir target pc", 32'(instr_pc), 32'h40);
        checkOutput("redir target instr", 32'(instr), 32'hA040);

        // Redirect with the queue full
        applyStimulus(1'b0, 1'b0, 8'h00);
        repeat (4) @(negedge clk);
        applyStimulus(1'b0, 1'b1, 8'h20);
        applyStimulus(1'b1, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("full redir rom_addr", 32'(rom_addr), 32'h20);
        repeat (2) @(negedge clk);
        checkOutput("full redir pc", 32'(instr_pc), 32'h20);
        checkOutput("full redir instr", 32'(instr), 32'hA020);

        // Back-to-back redirects; only the second counts and it wraps
        applyStimulus(1'b1, 1'b1, 8'h10);
        applyStimulus(1'b1, 1'b1, 8'hFF);
        applyStimulus(1'b1, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        checkOutput("b2b pc", 32'(instr_pc), 32'hFF);
        checkOutput("b2b instr", 32'(instr), 32'hA0FF);
        @(negedge clk);
        checkOutput("b2b wrap pc", 32'(instr_pc), 32'h00);

        // Reset with two words queued, then restart at RESET_PC
        applyStimulus(1'b0, 1'b0, 8'h00);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("full reset instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("full reset rom_en", 32'(rom_en), 32'd0);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        instr_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("restart pc", 32'(instr_pc), 32'h00);
        checkOutput("restart instr", 32'(instr), 32'hA000);

        // Random phase checked by the model
        for (int n = 0; n < 3000; n++) begin
            int r;
            @(posedge clk);
            #1;
            r           = int'($urandom_range(0, 199));
            reset       = (r < 2);
            redirect    = (r >= 2) && (r < 16);
            redirect_pc = 8'($urandom);
            instr_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        reset    = 1'b0;
        redirect = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
